// File: rtl/prog_seq_detector_pkg.sv
// rtl/prog_seq_detector_pkg.sv - shared types and compare helper for prog_seq_detector
// Purpose: detector state encoding, maximum pattern width, and the masked
//          pattern compare used by the top level.
// Ports:   none (package).
package seq_det_pkg;

  typedef enum logic {
    FILL  = 1'b0,   // fewer than PAT_W bits collected, no match possible
    ARMED = 1'b1    // history holds a full window, compare active
  } det_state_t;

  localparam int PAT_W_MAX = 32;

  // Callers zero-extend narrower operands; zero mask bits make the padding
  // positions don't-care, so any PAT_W up to PAT_W_MAX compares correctly.
  function automatic logic pat_match(input logic [PAT_W_MAX-1:0] hist,
                                     input logic [PAT_W_MAX-1:0] pat,
                                     input logic [PAT_W_MAX-1:0] mask);
    return ((hist ^ pat) & mask) == '0;
  endfunction

endpackage

// File: rtl/prog_seq_detector_if.sv
// rtl/prog_seq_detector_if.sv - stream, control and status bundle of prog_seq_detector
// Purpose: groups the serial input, pattern/control inputs and match outputs.
// Ports:   x, x_valid, pat_load, pat_in, overlap_en, cnt_clr (to detector),
//          z, match_cnt, cnt_sat (from detector); pat_mask_in when SEQ_MASK_EN.
// Modports: master drives the inputs, slave is the detector side.
interface prog_seq_detector_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             x;
  logic             x_valid;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic             overlap_en;
  logic             cnt_clr;
  logic             z;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

`ifdef SEQ_MASK_EN
  logic [PAT_W-1:0] pat_mask_in;

  modport master (output x, x_valid, pat_load, pat_in, pat_mask_in, overlap_en, cnt_clr,
                  input  z, match_cnt, cnt_sat);
  modport slave  (input  x, x_valid, pat_load, pat_in, pat_mask_in, overlap_en, cnt_clr,
                  output z, match_cnt, cnt_sat);
`else
  modport master (output x, x_valid, pat_load, pat_in, overlap_en, cnt_clr,
                  input  z, match_cnt, cnt_sat);
  modport slave  (input  x, x_valid, pat_load, pat_in, overlap_en, cnt_clr,
                  output z, match_cnt, cnt_sat);
`endif
endinterface

// File: rtl/seq_hist_shreg.sv
// rtl/seq_hist_shreg.sv - history shift register and fill tracker
// Purpose: holds the last PAT_W received bits and how many are valid.
// Ports:   clk, reset (async, active-high); shift (accept x), clear (drop
//          history), x; hist_shift = history with x appended, armed = full
//          window held, almost = one bit short of a full window.
//          The fill count saturates at PAT_W, so a full window stays armed.
module seq_hist_shreg
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift,
  input  logic             clear,
  input  logic             x,
  output logic [PAT_W-1:0] hist_shift,
  output logic             armed,
  output logic             almost
);
  localparam int             FW   = $clog2(PAT_W + 1);
  localparam logic [FW-1:0]  FULL = FW'(PAT_W);

  det_state_t       state_q, state_d;
  logic [FW-1:0]    fill_q,  fill_d;
  logic [PAT_W-1:0] hist_q,  hist_d;

  // Newest bit enters at the LSB; MSB is the oldest bit of the window.
  assign hist_shift = {hist_q[PAT_W-2:0], x};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      fill_q  <= '0;
      hist_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      hist_q  <= hist_d;
    end
  end

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clear) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift) begin
      hist_d = hist_shift;
      if (fill_q != FULL) fill_d = fill_q + FW'(1);
    end
    state_d = (fill_d == FULL) ? ARMED : FILL;
  end

  always_comb begin
    armed  = (state_q == ARMED);
    almost = (fill_q == FULL - FW'(1));
  end

endmodule

// File: rtl/prog_seq_detector.sv
// rtl/prog_seq_detector.sv - programmable serial sequence detector (top)
// Purpose: flags each occurrence of a runtime-loadable PAT_W-bit pattern in a
//          gated serial stream, overlapping or not, with a saturating counter.
// Ports:   clk, reset (async, active-high); bus (prog_seq_detector_if.slave):
//          x/x_valid stream, pat_load/pat_in pattern load, overlap_en,
//          cnt_clr in; z match pulse, match_cnt, cnt_sat out.
// Option:  SEQ_MASK_EN adds pat_mask_in and a mask register (0 = don't-care).
module prog_seq_detector
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] DEF_PAT = 4'b0110,
  parameter int               CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  prog_seq_detector_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PAT_W-1:0] pattern_q;
  logic [PAT_W-1:0] mask_q;
  logic [PAT_W-1:0] hist_shift;
  logic             armed, almost;
  logic             shift, match, hist_clear;
  logic             z_q, sat_q;
  logic [CNT_W-1:0] cnt_q;

  // A load owns the cycle: x is ignored and the history restarts.
  assign shift = bus.x_valid & ~bus.pat_load;

  // Match when this shift completes a full window: already armed, or one
  // bit short before the shift.
  assign match = shift & (armed | almost) &
                 pat_match(PAT_W_MAX'(hist_shift), PAT_W_MAX'(pattern_q), PAT_W_MAX'(mask_q));

  // Non-overlapping mode starts over after every match.
  assign hist_clear = bus.pat_load | (match & ~bus.overlap_en);

  seq_hist_shreg #(.PAT_W(PAT_W)) u_hist (
    .clk        (clk),
    .reset      (reset),
    .shift      (shift),
    .clear      (hist_clear),
    .x          (bus.x),
    .hist_shift (hist_shift),
    .armed      (armed),
    .almost     (almost)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern_q <= DEF_PAT;
    end else if (bus.pat_load) begin
      pattern_q <= bus.pat_in;
    end
  end

`ifdef SEQ_MASK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q <= '1;
    end else if (bus.pat_load) begin
      mask_q <= bus.pat_mask_in;
    end
  end
`else
  assign mask_q = '1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      z_q   <= 1'b0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      z_q <= match;
      if (bus.cnt_clr) begin
        // A match on the clearing edge is counted, not lost.
        cnt_q <= match ? CNT_W'(1) : '0;
        sat_q <= 1'b0;
      end else if (match && cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (cnt_q == CNT_MAX - CNT_W'(1)) sat_q <= 1'b1;
      end
    end
  end

  assign bus.z         = z_q;
  assign bus.match_cnt = cnt_q;
  assign bus.cnt_sat   = sat_q;

endmodule

// File: tb/tb_prog_seq_detector.sv
// tb/tb_prog_seq_detector.sv - self-checking bench for prog_seq_detector
module tb_prog_seq_detector;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  prog_seq_detector_if #(.PAT_W(4), .CNT_W(8)) if_a ();
  prog_seq_detector_if #(.PAT_W(4), .CNT_W(2)) if_b ();

  prog_seq_detector #(.PAT_W(4), .DEF_PAT(4'b0110), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a));
  prog_seq_detector #(.PAT_W(4), .DEF_PAT(4'b0110), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b));

  int total = 0;
  int bad   = 0;

  // Reference model: the received bits since the last restart, newest last.
  int m_pat, m_mask;
  bit m_bits[$];
  int m_cnt_a, m_cnt_b;
  bit m_sat_a, m_sat_b, m_z;

  typedef struct {
    bit       x;
    bit       xv;
    bit       pl;
    bit [3:0] pin;
    bit       ov;
    bit       clr;
    bit       ez;
    int       ec;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit x, input bit xv, input bit pl, input bit [3:0] pin,
                     input bit ov, input bit clr, input bit ez, input int ec);
    vec_t v;
    v.x = x; v.xv = xv; v.pl = pl; v.pin = pin; v.ov = ov; v.clr = clr; v.ez = ez; v.ec = ec;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pat = 6; m_mask = 15;
    m_bits.delete();
    m_cnt_a = 0; m_cnt_b = 0; m_sat_a = 0; m_sat_b = 0; m_z = 0;
  endfunction

  task automatic model_cnt(inout int cnt, inout bit sat, input int lim, input bit match, input bit clr);
    if (clr) begin
      cnt = match ? 1 : 0;
      sat = 0;
    end else if (match && cnt < lim) begin
      cnt++;
      if (cnt == lim) sat = 1;
    end
  endtask

  task automatic model_step(input bit x, input bit xv, input bit pl, input bit [3:0] pin,
                            input bit [3:0] pm, input bit ov, input bit clr);
    bit match = 0;
    int w = 0;
    if (pl) begin
      m_pat = int'(pin);
`ifdef SEQ_MASK_EN
      m_mask = int'(pm);
`endif
      m_bits.delete();
    end else if (xv) begin
      m_bits.push_back(x);
      if (m_bits.size() > 4) void'(m_bits.pop_front());
      if (m_bits.size() == 4) begin
        foreach (m_bits[i]) w = (w << 1) | int'(m_bits[i]);
        match = (((w ^ m_pat) & m_mask) == 0);
        if (match && !ov) m_bits.delete();
      end
    end
    m_z = match;
    model_cnt(m_cnt_a, m_sat_a, 255, match, clr);
    model_cnt(m_cnt_b, m_sat_b, 3, match, clr);
  endtask

  task automatic drive(input bit x, input bit xv, input bit pl, input bit [3:0] pin,
                       input bit [3:0] pm, input bit ov, input bit clr);
    if_a.x = x; if_a.x_valid = xv; if_a.pat_load = pl; if_a.pat_in = pin;
    if_a.overlap_en = ov; if_a.cnt_clr = clr;
    if_b.x = x; if_b.x_valid = xv; if_b.pat_load = pl; if_b.pat_in = pin;
    if_b.overlap_en = ov; if_b.cnt_clr = clr;
`ifdef SEQ_MASK_EN
    if_a.pat_mask_in = pm;
    if_b.pat_mask_in = pm;
`endif
  endtask

  task automatic cyc(input bit x, input bit xv, input bit pl, input bit [3:0] pin,
                     input bit [3:0] pm, input bit ov, input bit clr);
    drive(x, xv, pl, pin, pm, ov, clr);
    model_step(x, xv, pl, pin, pm, ov, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_z_a"},   int'(if_a.z),         int'(m_z));
    chk({tag, "_cnt_a"}, int'(if_a.match_cnt), m_cnt_a);
    chk({tag, "_sat_a"}, int'(if_a.cnt_sat),   int'(m_sat_a));
    chk({tag, "_z_b"},   int'(if_b.z),         int'(m_z));
    chk({tag, "_cnt_b"}, int'(if_b.match_cnt), m_cnt_b);
    chk({tag, "_sat_b"}, int'(if_b.cnt_sat),   int'(m_sat_b));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int sa[13];
    int sb[6];
    int sc[4];
    int ez[4];

    drive(0, 0, 0, 4'h0, 4'hF, 1, 0);
    model_reset();
    #15 reset = 1'b0;
    #1;
    chk("reset_z",   int'(if_a.z),         0);
    chk("reset_cnt", int'(if_a.match_cnt), 0);
    chk("reset_sat", int'(if_a.cnt_sat),   0);

    // Overlapping, default pattern 0110: matches after bits 4 and 7.
    add(0,1,0,0,1,0, 0,0); add(1,1,0,0,1,0, 0,0); add(1,1,0,0,1,0, 0,0); add(0,1,0,0,1,0, 1,1);
    add(1,1,0,0,1,0, 0,1); add(1,1,0,0,1,0, 0,1); add(0,1,0,0,1,0, 1,2);
    add(1,0,0,0,1,0, 0,2);
    // Restart via load of the same pattern, then non-overlapping: one match.
    add(0,0,1,4'h6,0,0, 0,2);
    add(0,1,0,0,0,0, 0,2); add(1,1,0,0,0,0, 0,2); add(1,1,0,0,0,0, 0,2); add(0,1,0,0,0,0, 1,3);
    add(1,1,0,0,0,0, 0,3); add(1,1,0,0,0,0, 0,3); add(0,1,0,0,0,0, 0,3);
    // Partial bits, then load 1011; earlier bits must not contribute.
    add(1,1,0,0,1,0, 0,3); add(0,1,0,0,1,0, 0,3);
    add(0,0,1,4'hB,1,0, 0,3);
    add(1,1,0,0,1,0, 0,3); add(0,1,0,0,1,0, 0,3); add(1,1,0,0,1,0, 0,3); add(1,1,0,0,1,0, 1,4);
    add(0,1,0,0,1,0, 0,4); add(1,1,0,0,1,0, 0,4); add(1,1,0,0,1,0, 1,5);
    // Gaps do not break a sequence.
    add(0,0,1,4'h6,1,0, 0,5);
    add(0,1,0,0,1,0, 0,5); add(1,1,0,0,1,0, 0,5);
    add(1,0,0,0,1,0, 0,5); add(1,0,0,0,1,0, 0,5); add(1,0,0,0,1,0, 0,5);
    add(1,1,0,0,1,0, 0,5); add(0,1,0,0,1,0, 1,6);
    add(0,0,0,0,1,1, 0,0);

    foreach (tbl[i]) begin
      cyc(tbl[i].x, tbl[i].xv, tbl[i].pl, tbl[i].pin, 4'hF, tbl[i].ov, tbl[i].clr);
      chk($sformatf("tbl%0d_z", i),   int'(if_a.z),         int'(tbl[i].ez));
      chk($sformatf("tbl%0d_cnt", i), int'(if_a.match_cnt), tbl[i].ec);
    end

    // Saturation on the 2-bit counter, then clear coincident with a match.
    do_reset();
    sa = '{0,1,1,0,1,1,0,1,1,0,1,1,0};
    for (int i = 0; i < 13; i++) begin
      cyc(sa[i][0], 1, 0, 4'h0, 4'hF, 1, 0);
      chk_model($sformatf("sat%0d", i));
      if (i == 9) chk("sat_reached_b", int'(if_b.cnt_sat), 1);
    end
    chk("sat_hold_cnt_b", int'(if_b.match_cnt), 3);
    chk("sat_hold_sat_b", int'(if_b.cnt_sat),   1);
    chk("sat_cnt_a",      int'(if_a.match_cnt), 4);
    cyc(1, 1, 0, 4'h0, 4'hF, 1, 0);
    cyc(1, 1, 0, 4'h0, 4'hF, 1, 0);
    cyc(0, 1, 0, 4'h0, 4'hF, 1, 1);
    chk("clr_match_z",     int'(if_b.z),         1);
    chk("clr_match_cnt_b", int'(if_b.match_cnt), 1);
    chk("clr_match_sat_b", int'(if_b.cnt_sat),   0);
    chk("clr_match_cnt_a", int'(if_a.match_cnt), 1);

    // Reset mid-stream discards a partial sequence immediately.
    do_reset();
    sb = '{0,1,1,0,1,1};
    for (int i = 0; i < 6; i++) begin
      cyc(sb[i][0], 1, 0, 4'h0, 4'hF, 1, 0);
      chk_model($sformatf("pre_rst%0d", i));
    end
    reset = 1'b1;
    #2;
    chk("async_rst_cnt", int'(if_a.match_cnt), 0);
    reset = 1'b0;
    model_reset();
    sc = '{0,1,1,0};
    ez = '{0,0,0,1};
    for (int i = 0; i < 4; i++) begin
      cyc(sc[i][0], 1, 0, 4'h0, 4'hF, 1, 0);
      chk($sformatf("post_rst%0d_z", i), int'(if_a.z), ez[i]);
    end

`ifdef SEQ_MASK_EN
    // Mask 1001 with pattern 0110: only the outer bits matter.
    cyc(0, 0, 1, 4'h6, 4'h9, 1, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 4'h0, 4'h9, 1, 0);
      chk($sformatf("mask%0d_z", i), int'(if_a.z), ez[i]);
    end
`endif

    // Randomized stimulus against the model.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      cyc(bit'($urandom_range(0, 1)),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 39) == 0),
          4'($urandom_range(0, 15)),
          4'($urandom_range(0, 15)),
          bit'($urandom_range(0, 1)),
          ($urandom_range(0, 49) == 0));
      chk_model($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_seq_detector.md
Name: prog_seq_detector

Overview:
Parametrised serial sequence detector. It watches a 1-bit stream `x` and flags each occurrence of a PAT_W-bit pattern. The pattern can be reloaded at runtime, and overlapping or non-overlapping detection is selectable per cycle. A saturating match counter is included. It sits after serial front-ends as a reusable drop-in for fixed-pattern detectors, with an optional don't-care mask.

Parameters:
- PAT_W, 4, pattern length in bits (2..32).
- DEF_PAT, 4'b0110, pattern loaded at reset. MSB is the first bit received.
- CNT_W, 8, match counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- x  in  1  serial data bit.
- x_valid  in  1  `x` is sampled only when high.
- pat_load  in  1  load `pat_in` into the pattern register.
- pat_in  in  PAT_W  new pattern, MSB first-received.
- overlap_en  in  1  1 = overlapping detection, 0 = non-overlapping.
- cnt_clr  in  1  synchronous clear of the match counter.
- z  out  1  match pulse, one cycle.
- match_cnt  out  CNT_W  number of matches, saturating.
- cnt_sat  out  1  sticky flag: counter reached all-ones.

Behaviour:
- Reset (async, active-high) drives:
  - pattern <= DEF_PAT
  - history <= 0
  - fill <= 0
  - z, match_cnt, cnt_sat <= 0
- Internal state: `history` is a PAT_W shift register; the newest bit enters at the LSB and the register shifts left. `fill` counts 0..PAT_W.
- FSM, derived from `fill`:
  - FILL (fill < PAT_W): no match possible.
  - ARMED (fill == PAT_W): compare active.
- Valid bit (x_valid=1, pat_load=0) at an edge:
  - history <= {history[PAT_W-2:0], x}.
  - fill increments, saturating at PAT_W.
  - match = (next history == pattern) AND (next fill == PAT_W).
- Latency: `z` is registered. It is high for exactly the cycle after the edge that sampled the completing bit. Minimum spacing is 1 cycle in overlap mode.
- On match with overlap_en=1: fill stays at PAT_W, so the pattern suffix can start the next match.
- On match with overlap_en=0: fill <= 0 and history <= 0. The next match needs PAT_W fresh valid bits.
- x_valid=0: history, fill and counter hold; `z` drops to 0 next cycle. Gaps do not break a sequence.
- pat_load=1 (priority over x_valid):
  - pattern <= pat_in, history <= 0, fill <= 0, z <= 0.
  - `x` is ignored that cycle.
  - The counter is unaffected.
- Counter on a match: match_cnt increments unless already all-ones. On reaching all-ones, cnt_sat <= 1. cnt_sat is sticky until reset or cnt_clr.
- cnt_clr: match_cnt <= 0, cnt_sat <= 0. If cnt_clr and a match occur at the same edge, the result is match_cnt = 1.
- overlap_en is sampled at the edge of the match; changing it mid-stream is legal.
- Reset asserted mid-stream: all state is cleared immediately. Any partial sequence is discarded and the pattern reverts to DEF_PAT.

Optional Feature:
- Macro: SEQ_MASK_EN.
- Defined:
  - Adds input `pat_mask_in` (PAT_W) and a mask register; reset value is all-ones.
  - The mask is loaded alongside pattern on pat_load.
  - Match = ((history ^ pattern) & mask) == 0. Mask bit 0 = don't-care.
- Undefined: no port and no register; exact compare only.

Decomposition:
- Package seq_det_pkg holds:
  - typedef enum {FILL, ARMED} det_state_t
  - constant PAT_W_MAX = 32
  - a compare function taking (history, pattern, mask)
- One sub-module, seq_hist_shreg: owns history and fill. It has shift, clear and saturate controls and outputs armed.
- The top level owns the pattern/mask registers, match logic, `z` and the counter.

Test Plan:
- Reset held 15 ns, default pattern 0110, overlap_en=1. Stream 0,1,1,0,1,1,0 → `z` pulses after bits 4 and 7; match_cnt = 2.
- Same stream with overlap_en=0 → single `z` after bit 4; match_cnt = 1.
- pat_load with pat_in=1011 mid-stream, then stream 1,0,1,1,0,1,1 → `z` after bits 4 and 7. Bits received before the load never contribute.
- Stream 0,1,(x_valid=0 for 3 cycles),1,0 → `z` after the final bit. No `z` while x_valid is low.
- CNT_W=2 with 4 matches → match_cnt sticks at 3, cnt_sat=1. cnt_clr coincident with a match → match_cnt = 1, cnt_sat = 0.
- Reset asserted after bits 0,1,1 then released, stream 0,1,1,0 → no `z` on the first 0; `z` after the final 0. With SEQ_MASK_EN, mask 1001 and pattern 0110: stream 0,0,0,0 → `z`.
